// File: rtl/weight_loader_pkg.sv
// Shared PE package: weight word width default and the loader FSM state type.
package weight_loader_pkg;

   localparam int WEIGHT_PAR_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } wl_state_e;

endpackage

// File: rtl/weight_loader.sv
// weight_loader: streams chainLen weights from a valid/ready source into a
// PE weight shift chain, last-PE weight first.
// Optional feature: define WEIGHT_LOADER_ABORT_EN to add the abort input.
//
// state | meaning
// IDLE  | waiting for start, wReady low
// LOAD  | accepting weights, one shift pulse per accepted word
// DONE  | final shift pulse is on the chain, done high for this cycle
module weight_loader
   import weight_loader_pkg::*;
#(
   parameter int weightPar = WEIGHT_PAR_DEFAULT,
   parameter int chainLen  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef WEIGHT_LOADER_ABORT_EN
   input  logic                 abort,
`endif
   input  logic                 start,
   input  logic                 wValid,
   input  logic [weightPar-1:0] wData,
   output logic                 wReady,
   output logic [weightPar-1:0] weight,
   output logic                 weightLoad,
   output logic                 busy,
   output logic                 done
);

   localparam int CNT_W = $clog2(chainLen + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(chainLen - 1);

   wl_state_e            state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [weightPar-1:0] weight_q;
   logic                 wload_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 xfer;
   logic                 abort_act;

`ifdef WEIGHT_LOADER_ABORT_EN
   assign abort_act = abort;
`else
   assign abort_act = 1'b0;
`endif

   // Ready is a pure decode of the state register, so wValid never reaches it.
   assign wReady = (state_q == LOAD);
   assign xfer   = wValid && wReady;

   assign weight     = weight_q;
   assign weightLoad = wload_q;
   assign busy       = busy_q;
   assign done       = done_q;

   // Sequencer: state, transfer counter and registered chain drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         weight_q <= '0;
         wload_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         wload_q <= 1'b0;
         if (abort_act && (state_q != IDLE)) begin
            // Abort wins over a same-cycle transfer; weight keeps its value.
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            if (xfer) begin
               weight_q <= wData;
               wload_q  <= 1'b1;
            end
            case (state_q)
               IDLE: begin
                  if (start) begin
                     state_q <= LOAD;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                  end
               end
               LOAD: begin
                  if (xfer) begin
                     cnt_q <= cnt_q + CNT_W'(1);
                     if (cnt_q == LAST_CNT) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end
                  end
               end
               DONE: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
